lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Receive-side companion to the 4-bit `lfsr` sequence generator.
- Consumes the generator's parallel state word `q`, one word per valid cycle, and self-synchronises a local LFSR to it.
- Reports lock status and counts sequence errors.
- Sits at the sink end of a PRBS test path, e.g. after a link or FIFO under test, so generator and checker form a closed loopback.

Parameters:
- WIDTH, 4: LFSR state/data width in bits.
- TAPS, 4'b1100: feedback tap mask.
  - next(s) = {s[WIDTH-2:0], ^(s & TAPS)}.
  - The default is maximal length, period 15.
- LOCK_CNT, 3: consecutive matching words after seeding required to declare lock (≥1).
- LOSS_CNT, 2: consecutive mismatching words in LOCKED that drop lock (≥1).
- CNT_W, 16: error counter width.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-low reset.
- din, input, WIDTH: received LFSR word.
- din_valid, input, 1: din qualifies this cycle.
- clr_cnt, input, 1: synchronous clear of err_cnt.
- locked, output, 1: checker is in LOCKED state.
- err, output, 1: one-cycle pulse per mismatching word while LOCKED.
- err_cnt, output, CNT_W: saturating count of err pulses.

Behaviour:
- Reset (rst=0, async): state=HUNT, exp=0, match_cnt=0, miss_cnt=0, locked=0, err=0, err_cnt=0.
- All registers update on the rising clk edge. When din_valid=0, state, exp and counters hold, and err=0.
- State machine (locked is a direct decode of state==LOCKED, no extra delay):
  - HUNT
    - Valid din≠0: exp<=next(din), match_cnt<=0, go to SYNC.
    - Valid din==0: stay in HUNT. All-zero is the illegal lockup state.
  - SYNC
    - Valid din==exp: exp<=next(din), match_cnt++. If match_cnt==LOCK_CNT-1, go to LOCKED and clear miss_cnt.
    - Valid din≠exp, din≠0: re-seed with exp<=next(din), match_cnt<=0, stay in SYNC.
    - Valid din==0: go to HUNT.
  - LOCKED
    - Valid din==exp: exp<=next(exp), miss_cnt<=0.
    - Valid din≠exp (including din==0): err<=1 on the following cycle. err_cnt increments, saturating at all-ones. exp<=next(exp) (flywheel; never re-seeded from bad data). miss_cnt++.
    - If miss_cnt==LOSS_CNT-1 on a mismatch, go to HUNT and clear match_cnt; locked falls on the same edge.
- Latency:
  - err is asserted for exactly one cycle, on the cycle after the edge that sampled the bad word.
  - err_cnt updates on the same edge err rises.
- err is never asserted in HUNT or SYNC. Mismatches there only affect acquisition.
- clr_cnt=1: err_cnt<=0 on the next edge. If a simultaneous error occurs, clear wins (err_cnt=0), but the err pulse is still emitted.
- Saturation: at err_cnt = 2^CNT_W-1, further errors pulse err but the count holds.
- Generator reset mid-stream: the stream discontinuity is treated as ordinary mismatches. Expected outcome is LOSS_CNT errors, then HUNT, then relock; no special handling.
- Reset mid-operation: an immediate async return to the reset values above, regardless of state.
- Widths: all comparisons are full WIDTH bits; no partial-word checking.

Decomposition:
- Shared package lfsr_pkg holds:
  - state enum lfsr_chk_state_t {HUNT, SYNC, LOCKED}, 2-bit;
  - function lfsr_next(state, taps), using the same shift/feedback convention as the generator so both ends share one definition;
  - default TAPS constant LFSR4_TAPS = 4'b1100.
- No sub-module: the datapath is one next-state function plus counters. The generator and checker both import lfsr_pkg.

Test Plan:
- Reference sequence for TAPS=1100 from seed 0001: 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000, then repeat.
- Acquisition: after reset, feed 0001, 0010, 0100, 1001 valid back-to-back -> locked rises on the edge sampling 1001; err stays 0; err_cnt=0.
- Single error: locked, send 0011 then 0111 (expected 0110) then 1101 -> one err pulse on the cycle after 0111; err_cnt=1; locked stays 1 (miss_cnt resets on 1101).
- Loss of lock: locked at exp=0011, send 0000, 0000 -> two err pulses; err_cnt=2; locked drops on the 2nd edge. Then 0101, 1011, 0111, 1111 -> relock on 1111.
- Valid gaps and zero hunt: in HUNT, send 0000 ×3 -> stay in HUNT. Then 1000, idle 5 cycles with din_valid=0 and din=garbage, then 0001, 0010, 0100 -> locked; idle cycles change nothing.
- Counter corners: with CNT_W=2, force 4 errors -> err_cnt saturates at 3 with 4 err pulses. Assert clr_cnt on the same cycle as a further error -> err_cnt=0 and err pulses.
- Async reset while locked: assert rst=0 mid-cycle -> locked, err and err_cnt go to 0 immediately without waiting for clk. After release, the stream resumes at 1010 -> HUNT, then SYNC, then relock after 3 matches.

Source files
------------

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR definitions for the PRBS generator and checker
package lfsr_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } lfsr_chk_state_t;

  localparam logic [3:0] LFSR4_TAPS = 4'b1100;

  // Shift left, feed the parity of the tapped bits into bit 0; callers narrow the result.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                            input logic [31:0] taps,
                                            input int          width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return ((state << 1) & mask) | {31'd0, ^(state & taps & mask)};
  endfunction

endpackage

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising PRBS checker with lock tracking and error count
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(LFSR4_TAPS),
  parameter int               LOCK_CNT = 3,
  parameter int               LOSS_CNT = 2,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int MW = $clog2(LOCK_CNT) + 1;
  localparam int LW = $clog2(LOSS_CNT) + 1;

  lfsr_chk_state_t  r_state, w_state_nxt;
  logic [WIDTH-1:0] r_exp, w_exp_nxt;
  logic [MW-1:0]    r_match, w_match_nxt;
  logic [LW-1:0]    r_miss, w_miss_nxt;
  logic             r_err, w_err_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] w_next_din, w_next_exp;

  assign w_next_din = WIDTH'(lfsr_next(32'(din), 32'(TAPS), WIDTH));
  assign w_next_exp = WIDTH'(lfsr_next(32'(r_exp), 32'(TAPS), WIDTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= HUNT;
      r_exp   <= '0;
      r_match <= '0;
      r_miss  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_exp   <= w_exp_nxt;
      r_match <= w_match_nxt;
      r_miss  <= w_miss_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    w_match_nxt = r_match;
    w_miss_nxt  = r_miss;
    w_err_nxt   = 1'b0;
    if (din_valid) begin
      case (r_state)
        HUNT: begin
          if (din != '0) begin
            w_exp_nxt   = w_next_din;
            w_match_nxt = '0;
            w_state_nxt = SYNC;
          end
        end
        SYNC: begin
          if (din == '0) begin
            w_state_nxt = HUNT;
          end else if (din == r_exp) begin
            w_exp_nxt   = w_next_din;
            w_match_nxt = r_match + MW'(1);
            if (r_match == MW'(LOCK_CNT - 1)) begin
              w_state_nxt = LOCKED;
              w_miss_nxt  = '0;
            end
          end else begin
            w_exp_nxt   = w_next_din;
            w_match_nxt = '0;
          end
        end
        LOCKED: begin
          // Flywheel: once locked, expectation advances on its own, never from received data.
          w_exp_nxt = w_next_exp;
          if (din == r_exp) begin
            w_miss_nxt = '0;
          end else begin
            w_err_nxt  = 1'b1;
            w_miss_nxt = r_miss + LW'(1);
            if (r_miss == LW'(LOSS_CNT - 1)) begin
              w_state_nxt = HUNT;
              w_match_nxt = '0;
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end

    if (clr_cnt)
      w_cnt_nxt = '0;
    else if (w_err_nxt && (r_cnt != '1))
      w_cnt_nxt = r_cnt + CNT_W'(1);
    else
      w_cnt_nxt = r_cnt;
  end

  assign locked  = (r_state == LOCKED);
  assign err     = r_err;
  assign err_cnt = r_cnt;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - directed and randomized checks of lfsr_checker against a sequence-table model
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  din;
  logic        din_valid;
  logic        clr_cnt;
  logic        locked16, err16, locked2, err2;
  logic [15:0] cnt16;
  logic [1:0]  cnt2;

  int n_vec = 0;
  int n_bad = 0;

  logic [3:0] seq [15];
  int         gp;

  int         m_state;
  logic [3:0] m_exp;
  int         m_match, m_miss;
  bit         m_err;
  int         m_cnt16, m_cnt2;

  localparam int LOCK_CNT = 3;
  localparam int LOSS_CNT = 2;

  always #5 clk = ~clk;

  lfsr_checker u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
    .locked(locked16), .err(err16), .err_cnt(cnt16)
  );

  lfsr_checker #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
    .locked(locked2), .err(err2), .err_cnt(cnt2)
  );

  function automatic logic [3:0] succ(input logic [3:0] x);
    for (int i = 0; i < 15; i++)
      if (seq[i] == x) return seq[(i + 1) % 15];
    return 4'd0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_exp = 4'd0; m_match = 0; m_miss = 0;
    m_err = 1'b0; m_cnt16 = 0; m_cnt2 = 0;
  endtask

  // 0 = hunting, 1 = confirming a seed, 2 = locked
  task automatic model_step(input bit v, input logic [3:0] d, input bit c);
    bit e;
    e = 1'b0;
    if (v) begin
      if (m_state == 0) begin
        if (d != 4'd0) begin m_exp = succ(d); m_match = 0; m_state = 1; end
      end else if (m_state == 1) begin
        if (d == 4'd0) m_state = 0;
        else if (d == m_exp) begin
          m_exp = succ(d);
          if (m_match == LOCK_CNT - 1) begin m_state = 2; m_miss = 0; end
          m_match++;
        end else begin
          m_exp = succ(d); m_match = 0;
        end
      end else begin
        if (d == m_exp) m_miss = 0;
        else begin
          e = 1'b1;
          if (m_miss == LOSS_CNT - 1) begin m_state = 0; m_match = 0; end
          m_miss++;
        end
        m_exp = succ(m_exp);
      end
    end
    m_err = e;
    if (c) begin m_cnt16 = 0; m_cnt2 = 0; end
    else if (e) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("locked",  32'(locked16), 32'(m_state == 2));
    chk("err",     32'(err16),    32'(m_err));
    chk("err_cnt", 32'(cnt16),    32'(m_cnt16));
    chk("locked2", 32'(locked2),  32'(m_state == 2));
    chk("err2",    32'(err2),     32'(m_err));
    chk("cnt2",    32'(cnt2),     32'(m_cnt2));
  endtask

  task automatic step(input bit v, input logic [3:0] d, input bit c);
    din = d; din_valid = v; clr_cnt = c;
    @(posedge clk);
    #1;
    model_step(v, d, c);
    check_all();
    @(negedge clk);
  endtask

  task automatic good(input bit c);
    step(1'b1, seq[gp], c);
    gp = (gp + 1) % 15;
  endtask

  task automatic bad(input bit c);
    logic [3:0] m;
    m = 4'($urandom_range(1, 15));
    step(1'b1, seq[gp] ^ m, c);
    gp = (gp + 1) % 15;
  endtask

  initial begin
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
            4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    rst = 1'b0; din = 4'd0; din_valid = 1'b0; clr_cnt = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // acquisition from seed 0001
    gp = 0;
    repeat (4) good(1'b0);
    chk("acq_locked", 32'(locked16), 32'd1);

    // single error in LOCKED
    good(1'b0);
    step(1'b1, 4'b0111, 1'b0);
    gp = 6;
    chk("single_err", 32'(err16), 32'd1);
    good(1'b0);
    chk("single_cnt", 32'(cnt16), 32'd1);

    // loss of lock at exp=0011, then relock on a shifted stream
    while (gp != 4) good(1'b0);
    step(1'b1, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    chk("loss_unlocked", 32'(locked16), 32'd0);
    gp = 8;
    repeat (4) good(1'b0);
    chk("relock", 32'(locked16), 32'd1);

    // counter corners: clear, four isolated errors, then clear colliding with an error
    good(1'b1);
    repeat (4) begin bad(1'b0); good(1'b0); end
    chk("sat_cnt2", 32'(cnt2), 32'd3);
    bad(1'b1);
    chk("clr_wins", 32'(cnt16), 32'd0);
    good(1'b0);

    // async reset while locked, no clock edge involved
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst_locked", 32'(locked16), 32'd0);
    chk("arst_err",    32'(err16),    32'd0);
    chk("arst_cnt",    32'(cnt16),    32'd0);
    @(negedge clk);
    rst = 1'b1;
    gp = 7;
    repeat (4) good(1'b0);
    chk("post_rst_lock", 32'(locked16), 32'd1);

    // drop to HUNT, zero words keep it there, idle gaps are transparent
    step(1'b1, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    repeat (3) step(1'b1, 4'b0000, 1'b0);
    chk("zero_hunt", 32'(locked16), 32'd0);
    gp = 14;
    good(1'b0);
    repeat (5) step(1'b0, 4'($urandom), 1'b0);
    repeat (3) good(1'b0);
    chk("gap_lock", 32'(locked16), 32'd1);

    // randomized stream: gaps, corrupted words, zeros, generator restarts, clears
    for (int i = 0; i < 600; i++) begin
      int r;
      bit c;
      r = $urandom_range(0, 99);
      c = ($urandom_range(0, 31) == 0);
      if (r < 15)      step(1'b0, 4'($urandom), c);
      else if (r < 25) bad(c);
      else if (r < 28) begin step(1'b1, 4'b0000, c); gp = (gp + 1) % 15; end
      else if (r < 30) begin gp = 0; good(c); end
      else             good(c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
